dice_roll_controller: RTL and testbench
=======================================

Name: dice_roll_controller

Overview:
- Requesting end of the dice roller interface: accepts a command (die type, roll count) and drives `die_select`/`roll` toward a dice roller.
- Samples each `rolled_number` at a fixed latency, converts it to a face value, and range-checks it.
- Accumulates sum/min/max over the command and presents one result via valid/ready.
- Sits between game-logic command sources and the dice roller.

Parameters:
- COUNT_W, 8, width of cmd_count and rolls_done
- SUM_W, 16, width of sum output (saturating)
- RESP_LATENCY, 2, cycles from roll pulse to valid rolled_number (legal 1..15)

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  reset, asynchronous, active-low
- cmd_valid  input  1  command present
- cmd_ready  output  1  high only in IDLE
- cmd_die  input  2  0=d4, 1=d6, 2=d8, 3=d20
- cmd_count  input  COUNT_W  number of rolls requested
- die_select  output  2  die type toward roller
- roll  output  1  one-cycle roll request toward roller
- rolled_number  input  8  raw roll from roller, nominal range 0..faces-1
- result_valid  output  1  result available
- result_ready  input  1  consumer accepts result
- sum  output  SUM_W  sum of face values (raw+1)
- min_face  output  8  smallest face value
- max_face  output  8  largest face value
- rolls_done  output  COUNT_W  rolls completed
- range_error  output  1  any raw value >= faces during this command

Behaviour:
- Reset (async, `reset`=0) clears all state:
  - FSM goes to IDLE; `cmd_ready` is 1 (it is high whenever the FSM is in IDLE).
  - `roll`, `result_valid`, `range_error` are 0.
  - `sum`, `min_face`, `max_face`, `rolls_done`, `die_select` are 0.
- States: IDLE, ROLL, WAIT, DONE.
- IDLE:
  - On `cmd_valid` && `cmd_ready`: latch `cmd_die` into `die_select` and latch `cmd_count`.
  - Clear `sum`, `min_face`, `max_face`, `rolls_done`, `range_error`.
  - If `cmd_count`==0, go to DONE. Otherwise go to ROLL.
- ROLL:
  - `roll`=1 for exactly this cycle (registered output).
  - Load the wait counter with RESP_LATENCY and go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - On the cycle the counter reaches 1, sample `rolled_number` at the closing edge.
  - If roll is issued in cycle t, the sample is taken at the edge ending cycle t+RESP_LATENCY.
  - Roll period is RESP_LATENCY+1 cycles.
- Sample processing (at the sample edge):
  - faces = 4/6/8/20 from `die_select`.
  - If raw >= faces: set `range_error` (sticky until the next command) and use face = faces (clamp).
  - Otherwise face = raw+1.
  - `sum` += face, saturating at 2^SUM_W-1.
  - First sample of a command sets both `min_face` and `max_face` to face; later samples update with <, >.
  - `rolls_done` increments.
  - If `rolls_done`+1 == latched count, go to DONE. Otherwise go to ROLL next cycle.
- DONE:
  - `result_valid`=1; `sum`, `min_face`, `max_face`, `rolls_done`, `range_error` held stable.
  - On `result_ready`=1: go to IDLE next cycle with `result_valid`=0.
  - Same-cycle command acceptance is not possible, because `cmd_ready`=0 in DONE.
- `die_select` holds its value from command accept until the next accepted command; it does not change during ROLL or WAIT.
- `rolled_number` is ignored outside sample edges.
- Zero-count command: DONE on the cycle after accept, with all result fields 0 and no `roll` pulse.
- Reset mid-command: everything returns to reset values immediately; no further `roll` pulses; any partial result is discarded.
- `cmd_valid` is ignored outside IDLE.

Optional Feature:
- Macro: DICE_ROLL_ABORT_EN.
- When defined:
  - Adds input port `abort` (1 bit).
  - `abort`=1 in ROLL or WAIT: any in-flight sample is discarded and the FSM goes to DONE next cycle, reporting the partial results accumulated so far.
  - Adds output `aborted` (1 bit), set with `result_valid` and cleared on return to IDLE.
  - `abort` in IDLE or DONE is ignored.
- When undefined: no `abort`/`aborted` ports; behaviour exactly as above.

Test Plan:
- Reset, then `cmd_die`=1 (d6), `cmd_count`=3, roller model returns 0,5,2 -> `roll` pulses at t+1, t+4, t+7 (RESP_LATENCY=2); result `sum`=10, `min_face`=1, `max_face`=6, `rolls_done`=3, `range_error`=0.
- d4, count=2, raw 7 then 1 -> `range_error`=1, `sum`=4+2=6, `max_face`=4, `min_face`=2.
- count=0 with d20 -> `result_valid` one cycle after accept, no `roll` pulse, all result fields 0.
- d20, count=255, SUM_W=8, raw always 19 -> `sum` saturates at 255, `rolls_done`=255, `max_face`=`min_face`=20.
- DONE with `result_ready` held 0 for 5 cycles while `cmd_valid`=1 -> outputs stable, `cmd_ready`=0, command not accepted until the cycle after `result_ready`=1.
- Assert `reset` during the WAIT of the 2nd roll of a count=4 command -> all outputs 0, no further `roll`; a new command afterwards runs cleanly. With DICE_ROLL_ABORT_EN: `abort` in the 3rd WAIT -> `rolls_done`=2, `aborted`=1.

Source files
------------

// File: rtl/dice_roll_controller.sv
// rtl/dice_roll_controller.sv - dice roller requester with sum/min/max accumulation
// Optional abort input and aborted flag enabled by DICE_ROLL_ABORT_EN.
module dice_roll_controller #(
    parameter int COUNT_W      = 8,
    parameter int SUM_W        = 16,
    parameter int RESP_LATENCY = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_die,
    input  logic [COUNT_W-1:0] cmd_count,
    output logic [1:0]         die_select,
    output logic               roll,
    input  logic [7:0]         rolled_number,
    output logic               result_valid,
    input  logic               result_ready,
    output logic [SUM_W-1:0]   sum,
    output logic [7:0]         min_face,
    output logic [7:0]         max_face,
    output logic [COUNT_W-1:0] rolls_done,
    output logic               range_error
`ifdef DICE_ROLL_ABORT_EN
    ,
    input  logic               abort,
    output logic               aborted
`endif
);

    typedef enum logic [1:0] {IDLE, ROLL, WAIT, DONE} state_t;

    localparam logic [3:0] LATENCY = 4'(RESP_LATENCY);

    state_t             state;
    logic [COUNT_W-1:0] count;
    logic [3:0]         wait_cnt;

    logic [7:0]         faces;
    logic               over;
    logic [7:0]         face;
    logic [SUM_W:0]     sum_ext;
    logic [SUM_W-1:0]   sum_next;
    logic [COUNT_W:0]   done_inc;
    logic               last_roll;
    logic               abort_hit;

    always_comb begin
        faces = 8'd20;
        case (die_select)
            2'd0:    faces = 8'd4;
            2'd1:    faces = 8'd6;
            2'd2:    faces = 8'd8;
            default: faces = 8'd20;
        endcase
    end

    // Out-of-range raw values are clamped to the top face so the stats stay meaningful.
    assign over      = rolled_number >= faces;
    assign face      = over ? faces : rolled_number + 8'd1;
    assign sum_ext   = {1'b0, sum} + (SUM_W+1)'(face);
    assign sum_next  = sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
    assign done_inc  = {1'b0, rolls_done} + (COUNT_W+1)'(1);
    assign last_roll = done_inc == {1'b0, count};

`ifdef DICE_ROLL_ABORT_EN
    assign abort_hit = abort && (state == ROLL || state == WAIT);
`else
    assign abort_hit = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cmd_ready    <= 1'b1;
            die_select   <= 2'd0;
            roll         <= 1'b0;
            result_valid <= 1'b0;
            sum          <= '0;
            min_face     <= 8'd0;
            max_face     <= 8'd0;
            rolls_done   <= '0;
            range_error  <= 1'b0;
            count        <= '0;
            wait_cnt     <= 4'd0;
`ifdef DICE_ROLL_ABORT_EN
            aborted      <= 1'b0;
`endif
        end else begin
            roll <= 1'b0;
            if (abort_hit) begin
                // The sample due at this edge (if any) is dropped; partial stats are reported.
                state        <= DONE;
                result_valid <= 1'b1;
`ifdef DICE_ROLL_ABORT_EN
                aborted      <= 1'b1;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        if (cmd_valid) begin
                            die_select  <= cmd_die;
                            count       <= cmd_count;
                            sum         <= '0;
                            min_face    <= 8'd0;
                            max_face    <= 8'd0;
                            rolls_done  <= '0;
                            range_error <= 1'b0;
                            cmd_ready   <= 1'b0;
                            if (cmd_count == '0) begin
                                state        <= DONE;
                                result_valid <= 1'b1;
                            end else begin
                                state <= ROLL;
                                roll  <= 1'b1;
                            end
                        end
                    end
                    ROLL: begin
                        wait_cnt <= LATENCY;
                        state    <= WAIT;
                    end
                    WAIT: begin
                        wait_cnt <= wait_cnt - 4'd1;
                        if (wait_cnt == 4'd1) begin
                            sum         <= sum_next;
                            rolls_done  <= done_inc[COUNT_W-1:0];
                            range_error <= range_error | over;
                            if (rolls_done == '0 || face < min_face)
                                min_face <= face;
                            if (rolls_done == '0 || face > max_face)
                                max_face <= face;
                            if (last_roll) begin
                                state        <= DONE;
                                result_valid <= 1'b1;
                            end else begin
                                state <= ROLL;
                                roll  <= 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        if (result_ready) begin
                            state        <= IDLE;
                            result_valid <= 1'b0;
                            cmd_ready    <= 1'b1;
`ifdef DICE_ROLL_ABORT_EN
                            aborted      <= 1'b0;
`endif
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dice_roll_controller.sv
// tb/tb_dice_roll_controller.sv - self-checking bench for dice_roll_controller
module tb_dice_roll_controller;

    localparam int COUNT_W = 8;
    localparam int SUM_W   = 8;
    localparam int LAT     = 2;
    localparam int PER     = LAT + 1;

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic [1:0]         cmd_die = 2'd0;
    logic [COUNT_W-1:0] cmd_count = '0;
    logic [1:0]         die_select;
    logic               roll;
    logic [7:0]         rolled_number = 8'hEE;
    logic               result_valid;
    logic               result_ready = 1'b0;
    logic [SUM_W-1:0]   sum;
    logic [7:0]         min_face;
    logic [7:0]         max_face;
    logic [COUNT_W-1:0] rolls_done;
    logic               range_error;
`ifdef DICE_ROLL_ABORT_EN
    logic               abort = 1'b0;
    logic               aborted;
    logic               abort_in;
    assign abort_in = abort;
`else
    logic               abort_in;
    assign abort_in = 1'b0;
`endif

    dice_roll_controller #(.COUNT_W(COUNT_W), .SUM_W(SUM_W), .RESP_LATENCY(LAT)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_die(cmd_die), .cmd_count(cmd_count),
        .die_select(die_select), .roll(roll), .rolled_number(rolled_number),
        .result_valid(result_valid), .result_ready(result_ready),
        .sum(sum), .min_face(min_face), .max_face(max_face),
        .rolls_done(rolls_done), .range_error(range_error)
`ifdef DICE_ROLL_ABORT_EN
        , .abort(abort), .aborted(aborted)
`endif
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    int n_roll = 0;
    int raws [256];

    typedef struct { int sum; int mn; int mx; int done; int err; } res_t;

    // Model: 0 = idle, 1 = rolling, 2 = result held. m_k counts cycles since accept.
    int   m_state = 0;
    int   m_k = 0;
    int   m_n = 0;
    int   m_die = 0;
    int   m_acc = 0;
    int   m_ab = 0;
    res_t exp_r;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic res_t results(input int r, input int die);
        res_t x;
        int fc;
        int f;
        fc = (die == 0) ? 4 : (die == 1) ? 6 : (die == 2) ? 8 : 20;
        x.sum = 0; x.mn = 0; x.mx = 0; x.err = 0; x.done = r;
        for (int i = 0; i < r; i++) begin
            f = (raws[i] >= fc) ? fc : raws[i] + 1;
            if (raws[i] >= fc) x.err = 1;
            x.sum += f;
            if (i == 0 || f < x.mn) x.mn = f;
            if (i == 0 || f > x.mx) x.mx = f;
        end
        if (x.sum > (1 << SUM_W) - 1) x.sum = (1 << SUM_W) - 1;
        return x;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_state <= 0; m_k <= 0; m_die <= 0; m_ab <= 0;
        end else begin
            case (m_state)
                0: if (cmd_valid) begin
                    m_die <= int'(cmd_die);
                    m_n   <= int'(cmd_count);
                    m_k   <= 1;
                    m_ab  <= 0;
                    m_acc <= m_acc + 1;
                    if (cmd_count == 0) begin
                        m_state <= 2;
                        exp_r   <= results(0, int'(cmd_die));
                    end else begin
                        m_state <= 1;
                    end
                end
                1: begin
                    if (abort_in) begin
                        m_state <= 2;
                        m_ab    <= 1;
                        exp_r   <= results((m_k - 1) / PER, m_die);
                    end else if (m_k + 1 == 1 + m_n * PER) begin
                        m_state <= 2;
                        exp_r   <= results(m_n, m_die);
                    end
                    m_k <= m_k + 1;
                end
                default: if (result_ready) m_state <= 0;
            endcase
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            chk("rst_cmd_ready", cmd_ready, 1);
            chk("rst_roll", roll, 0);
            chk("rst_result_valid", result_valid, 0);
            chk("rst_range_error", range_error, 0);
            chk("rst_sum", sum, 0);
            chk("rst_min", min_face, 0);
            chk("rst_max", max_face, 0);
            chk("rst_rolls_done", rolls_done, 0);
            chk("rst_die_select", die_select, 0);
        end else begin
            if (roll) n_roll++;
            chk("die_select", die_select, m_die);
            case (m_state)
                0: begin
                    chk("idle_cmd_ready", cmd_ready, 1);
                    chk("idle_roll", roll, 0);
                    chk("idle_result_valid", result_valid, 0);
`ifdef DICE_ROLL_ABORT_EN
                    chk("idle_aborted", aborted, 0);
`endif
                end
                1: begin
                    chk("busy_cmd_ready", cmd_ready, 0);
                    chk("busy_result_valid", result_valid, 0);
                    chk("busy_roll", roll, ((m_k - 1) % PER == 0) ? 1 : 0);
                end
                default: begin
                    chk("done_cmd_ready", cmd_ready, 0);
                    chk("done_roll", roll, 0);
                    chk("done_result_valid", result_valid, 1);
                    chk("done_sum", sum, exp_r.sum);
                    chk("done_min", min_face, exp_r.mn);
                    chk("done_max", max_face, exp_r.mx);
                    chk("done_rolls_done", rolls_done, exp_r.done);
                    chk("done_range_error", range_error, exp_r.err);
`ifdef DICE_ROLL_ABORT_EN
                    chk("done_aborted", aborted, m_ab);
`endif
                end
            endcase
        end
    end

    // Roller stand-in: the raw value is only present on the cycle it must be sampled.
    task automatic step();
        @(posedge clock);
        #1;
        if (m_state == 1 && (m_k - 1) % PER == LAT)
            rolled_number = 8'(raws[(m_k - 1) / PER]);
        else
            rolled_number = 8'hEE;
    endtask

    task automatic issue(input int die, input int n);
        int a0;
        a0 = m_acc;
        cmd_die   = 2'(die);
        cmd_count = COUNT_W'(n);
        cmd_valid = 1'b1;
        for (int i = 0; i < 100 && m_acc == a0; i++) step();
        if (m_acc == a0) chk("accept_timeout", 0, 1);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 2000 && m_state != 2; i++) step();
        if (m_state != 2) chk("done_timeout", 0, 1);
    endtask

    task automatic release_result();
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
    endtask

    int r0;

    initial begin
        step(); step();
        chk("lit_reset_cmd_ready", cmd_ready, 1);
        chk("lit_reset_sum", sum, 0);
        reset = 1'b1;
        step();

        // d6 x3, raw 0,5,2
        raws[0] = 0; raws[1] = 5; raws[2] = 2;
        r0 = n_roll;
        issue(1, 3);
        wait_done();
        chk("lit1_sum", sum, 10);
        chk("lit1_min", min_face, 1);
        chk("lit1_max", max_face, 6);
        chk("lit1_rolls_done", rolls_done, 3);
        chk("lit1_range_error", range_error, 0);
        chk("lit1_roll_pulses", n_roll - r0, 3);
        release_result();

        // d4 x2, raw 7 (out of range) then 1
        raws[0] = 7; raws[1] = 1;
        issue(0, 2);
        wait_done();
        chk("lit2_range_error", range_error, 1);
        chk("lit2_sum", sum, 6);
        chk("lit2_max", max_face, 4);
        chk("lit2_min", min_face, 2);
        release_result();

        // zero-count d20
        r0 = n_roll;
        issue(3, 0);
        chk("lit3_result_valid", result_valid, 1);
        chk("lit3_sum", sum, 0);
        chk("lit3_rolls_done", rolls_done, 0);
        release_result();
        chk("lit3_no_roll", n_roll - r0, 0);

        // d20 x255 saturating
        for (int i = 0; i < 255; i++) raws[i] = 19;
        issue(3, 255);
        wait_done();
        chk("lit4_sum", sum, 255);
        chk("lit4_rolls_done", rolls_done, 255);
        chk("lit4_min", min_face, 20);
        chk("lit4_max", max_face, 20);
        release_result();

        // result held with back-pressure while a new command waits
        raws[0] = 3;
        issue(2, 1);
        wait_done();
        raws[0] = 5;
        cmd_die = 2'd1; cmd_count = COUNT_W'(1); cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("lit5_held_cmd_ready", cmd_ready, 0);
        chk("lit5_held_sum", sum, 4);
        release_result();
        chk("lit5_idle_cmd_ready", cmd_ready, 1);
        step();
        chk("lit5_accepted_roll", roll, 1);
        cmd_valid = 1'b0;
        wait_done();
        chk("lit5_sum", sum, 6);
        release_result();

        // reset during the second roll's wait
        raws[0] = 1; raws[1] = 2; raws[2] = 3; raws[3] = 4;
        issue(1, 4);
        for (int i = 0; i < 20 && m_k != 5; i++) step();
        chk("lit6_reached_wait", m_k, 5);
        reset = 1'b0;
        #1;
        chk("lit6_rst_rolls_done", rolls_done, 0);
        chk("lit6_rst_cmd_ready", cmd_ready, 1);
        r0 = n_roll;
        step(); step();
        reset = 1'b1;
        step(); step();
        chk("lit6_no_roll", n_roll - r0, 0);
        raws[0] = 0; raws[1] = 0;
        issue(1, 2);
        wait_done();
        chk("lit6_clean_sum", sum, 2);
        release_result();

`ifdef DICE_ROLL_ABORT_EN
        raws[0] = 1; raws[1] = 2; raws[2] = 3; raws[3] = 4;
        issue(1, 4);
        for (int i = 0; i < 20 && m_k != 8; i++) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        wait_done();
        chk("lit7_rolls_done", rolls_done, 2);
        chk("lit7_aborted", aborted, 1);
        chk("lit7_sum", sum, 5);
        release_result();
`endif

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
